// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1 UART transmitter fed by the register-dump FIFO
// tx_done_tick doubles as the FIFO read strobe, so consecutive bytes go out back-to-back.
module uart_tx_serializer #(
  parameter int DBIT       = 8,
  parameter int BAUD_DIV   = 163,
  parameter int OS_TICKS   = 16,
  parameter int STOP_TICKS = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx,
  output logic            busy,
  output logic            tx_done_tick
);

  localparam int TICK_MAX = (OS_TICKS > STOP_TICKS) ? OS_TICKS : STOP_TICKS;
  localparam int DIV_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int TCK_W    = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int BIT_W    = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BAUD_DIV - 1);
  localparam logic [TCK_W-1:0] OS_LAST   = TCK_W'(OS_TICKS - 1);
  localparam logic [TCK_W-1:0] STOP_LAST = TCK_W'(STOP_TICKS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DBIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e            state_q;
  logic [DIV_W-1:0]  div_q;
  logic [TCK_W-1:0]  tick_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DBIT-1:0]   shift_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;
  logic              s_tick;

  assign s_tick       = (div_q == DIV_LAST);
  assign tx           = tx_q;
  assign busy         = busy_q;
  assign tx_done_tick = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Divider is pinned to zero while idle so each frame is phase-aligned to its accept edge.
      if (state_q == IDLE) begin
        div_q <= '0;
      end else begin
        div_q <= s_tick ? '0 : div_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (tx_start) begin
            shift_q <= din;
            tx_q    <= 1'b0;
            tick_q  <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (s_tick) begin
            if (tick_q == OS_LAST) begin
              tick_q  <= '0;
              bit_q   <= '0;
              tx_q    <= shift_q[0];
              state_q <= DATA;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (tick_q == OS_LAST) begin
              tick_q <= '0;
              if (bit_q == BIT_LAST) begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end else begin
                shift_q <= shift_q >> 1;
                tx_q    <= shift_q[1];
                bit_q   <= bit_q + 1'b1;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (tick_q == STOP_LAST) begin
              tick_q  <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - directed and random frames checked against a bit-slot line model
module tb_uart_tx_serializer;

  localparam int DBIT  = 8;
  localparam int BDIV  = 2;
  localparam int P     = 16 * BDIV;
  localparam int S     = 16 * BDIV;
  localparam int FRAME = (DBIT + 1) * P + S;
  localparam int NLOG  = 1300;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start;
  logic [7:0] din;
  logic       tx;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic     tx_log [NLOG];
  int       done_at[$];
  logic [7:0] fifo_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_tx_serializer #(
    .DBIT(DBIT), .BAUD_DIV(BDIV), .OS_TICKS(16), .STOP_TICKS(16)
  ) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .din(din),
    .tx(tx), .busy(busy), .tx_done_tick(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line level t cycles after the accept edge: start slot low, data LSB first, then high.
  function automatic logic model_tx(input logic [7:0] b, input int t);
    if (t < P) return 1'b0;
    if (t < (DBIT + 1) * P) return b[t / P - 1];
    return 1'b1;
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit disturb, input string tag);
    din      = b;
    tx_start = 1'b1;
    @(posedge clk);
    for (int t = 0; t <= FRAME + 1; t++) begin
      @(negedge clk);
      check({tag, ".tx"}, tx, model_tx(b, t));
      check({tag, ".busy"}, busy, (t < FRAME));
      check({tag, ".done"}, done, (t == FRAME));
      if (disturb && t >= 100 && t < FRAME) begin
        tx_start = 1'b1;
        din      = 8'hFF;
      end else begin
        tx_start = 1'b0;
      end
    end
  endtask

  initial begin
    int c;
    int ndone;
    logic [7:0] v;

    reset    = 1'b1;
    tx_start = 1'b1;
    din      = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst.tx", tx, 1'b1);
      check("rst.busy", busy, 1'b0);
      check("rst.done", done, 1'b0);
    end
    reset    = 1'b0;
    tx_start = 1'b0;
    @(negedge clk);
    check("post_rst.busy", busy, 1'b0);
    check("post_rst.tx", tx, 1'b1);

    send_frame(8'hA5, 1'b0, "a5");
    send_frame(8'hA5, 1'b1, "disturb");
    send_frame(8'h00, 1'b0, "zeros");
    send_frame(8'hFF, 1'b0, "ones");
    for (int r = 0; r < 3; r++) begin
      send_frame(8'($urandom), 1'b0, "rand");
    end

    // Reset lands inside data bit 4; the partial frame must vanish without a done strobe.
    din      = 8'($urandom);
    tx_start = 1'b1;
    @(posedge clk);
    for (int t = 0; t < 5 * P + 5; t++) begin
      @(negedge clk);
      tx_start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check("midrst.tx", tx, 1'b1);
    check("midrst.busy", busy, 1'b0);
    check("midrst.done", done, 1'b0);
    reset = 1'b0;
    ndone = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (done === 1'b1 || busy !== 1'b0) ndone++;
    end
    check("midrst.quiet", ndone, 0);
    send_frame(8'h3C, 1'b0, "after_rst");

    // FIFO chain: bytes of one register word, low byte first, advanced by tx_done_tick.
    v = 8'hAF; fifo_q.push_back(v); exp_q.push_back(v);
    v = 8'hD7; fifo_q.push_back(v); exp_q.push_back(v);
    v = 8'hEB; fifo_q.push_back(v); exp_q.push_back(v);
    v = 8'h05; fifo_q.push_back(v); exp_q.push_back(v);
    tx_start = 1'b1;
    din      = fifo_q[0];
    @(posedge clk);
    for (int cyc = 0; cyc < NLOG; cyc++) begin
      @(negedge clk);
      tx_log[cyc] = tx;
      if (done === 1'b1) begin
        done_at.push_back(cyc);
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      end
      tx_start = (fifo_q.size() > 0);
      din      = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end
    c = 0;
    while (c + (DBIT + 1) * P + P / 2 < NLOG) begin
      if (tx_log[c] == 1'b0) begin
        check("chain.start_mid", tx_log[c + P / 2], 1'b0);
        for (int k = 0; k < DBIT; k++) v[k] = tx_log[c + (k + 1) * P + P / 2];
        check("chain.stop_mid", tx_log[c + (DBIT + 1) * P + P / 2], 1'b1);
        got_q.push_back(v);
        c = c + FRAME;
      end else begin
        c++;
      end
    end
    check("chain.nframes", got_q.size(), 4);
    for (int k = 0; k < 4 && k < got_q.size(); k++) check("chain.byte", got_q[k], exp_q[k]);
    check("chain.ndone", done_at.size(), 4);
    if (done_at.size() > 0) check("chain.first_done", done_at[0], FRAME);
    for (int k = 1; k < done_at.size(); k++) check("chain.spacing", done_at[k] - done_at[k - 1], FRAME + 1);
    check("chain.fifo_empty", fifo_q.size(), 0);
    check("chain.idle_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
